// File: rtl/his_peak_reader.sv
// his_peak_reader
// Histogram readout engine on the read side of the histogram bank RAM.
// Once a bank is complete, it sweeps every bin of that bank once. It tracks
// the maximum count and its bin index (the coarse ToF peak). It clears each
// bin after reading it, so the bank is empty for the next acquisition.
//
// Ports:
//   clk, res        - rising-edge clock, asynchronous active-low reset
//   start, hisNum   - start pulse and bank select, sampled together in IDLE
//   rdEn/rdBank/rdAddr, rdData
//                   - RAM read port; data returns one cycle after rdEn
//   clrEn/clrAddr   - write-zero strobe for the bin just returned
//   busy            - readout in progress
//   peakValid       - one-cycle pulse when peakBin/peakCount are final
//   peakBin/Count   - maximum count and lowest bin holding it
//   binValid/binReady/binAddr/binData
//                   - raw-bin stream port, only with HIS_STREAM_OUT_EN
//
// Optional feature macro: HIS_STREAM_OUT_EN
//   Adds the stream port, fed through a 2-entry buffer. When this macro is
//   defined, reads are throttled by back-pressure, and DONE waits until the
//   last bin has been accepted.
module his_peak_reader #(
  parameter int NB = 6,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          hisNum,
  output logic          rdEn,
  output logic          rdBank,
  output logic [NB-1:0] rdAddr,
  input  logic [CW-1:0] rdData,
  output logic          clrEn,
  output logic [NB-1:0] clrAddr,
  output logic          busy,
  output logic          peakValid,
  output logic [NB-1:0] peakBin,
  output logic [CW-1:0] peakCount
`ifdef HIS_STREAM_OUT_EN
  ,
  output logic          binValid,
  input  logic          binReady,
  output logic [NB-1:0] binAddr,
  output logic [CW-1:0] binData
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [NB-1:0] LAST_ADDR = '1;

  state_e        state_q, state_d;
  logic          bank_q, bank_d;
  logic [NB-1:0] addr_q, addr_d;
  logic          clr_en_q, clr_en_d;
  logic [NB-1:0] clr_addr_q, clr_addr_d;
  logic          busy_q, busy_d;
  logic          peak_valid_q, peak_valid_d;
  logic [NB-1:0] peak_bin_q, peak_bin_d;
  logic [CW-1:0] peak_count_q, peak_count_d;

  logic          issue_ok;
  logic          sweep_done;
  logic          rd_en;

`ifdef HIS_STREAM_OUT_EN
  logic [1:0][NB-1:0] buf_addr_q, buf_addr_d;
  logic [1:0][CW-1:0] buf_data_q, buf_data_d;
  logic [1:0]         buf_cnt_q, buf_cnt_d;
  logic               buf_rd_q, buf_rd_d;
  logic               buf_wr_q, buf_wr_d;
  logic               buf_push;
  logic               buf_pop;
  logic               bin_valid;

  assign bin_valid = (buf_cnt_q != 2'd0);
  assign buf_pop   = bin_valid && binReady;
  // Every returned bin (marked by the clear strobe) enters the buffer.
  assign buf_push  = clr_en_q;

  // A read is allowed only if its data will have a slot when it arrives.
  // Occupancy is counted after this cycle's pop, so that with binReady held
  // high the engine sustains one bin per cycle. Reads are never issued while
  // the buffer is full, even if it is draining.
  assign issue_ok = (buf_cnt_q != 2'd2) &&
                    (({1'b0, buf_cnt_q} + 3'(clr_en_q)) < (3'd2 + 3'(buf_pop)));

  // The sweep is finished once nothing is in flight, and the buffer is empty
  // or is handing over its final entry this cycle.
  assign sweep_done = !clr_en_q &&
                      ((buf_cnt_q == 2'd0) || ((buf_cnt_q == 2'd1) && buf_pop));

  assign binValid = bin_valid;
  assign binAddr  = buf_addr_q[buf_rd_q];
  assign binData  = buf_data_q[buf_rd_q];

  // Two-entry ring buffer between RAM return and the stream port.
  always_comb begin
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_rd_d   = buf_rd_q;
    buf_wr_d   = buf_wr_q;
    if (buf_push) begin
      buf_addr_d[buf_wr_q] = clr_addr_q;
      buf_data_d[buf_wr_q] = rdData;
      buf_wr_d             = ~buf_wr_q;
    end
    if (buf_pop) begin
      buf_rd_d = ~buf_rd_q;
    end
    buf_cnt_d = buf_cnt_q + 2'(buf_push) - 2'(buf_pop);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      buf_addr_q <= '0;
      buf_data_q <= '0;
      buf_cnt_q  <= '0;
      buf_rd_q   <= 1'b0;
      buf_wr_q   <= 1'b0;
    end else begin
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      buf_cnt_q  <= buf_cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_wr_q   <= buf_wr_d;
    end
  end
`else
  // Without the stream port nothing throttles reads, and DRAIN lasts one cycle.
  assign issue_ok   = 1'b1;
  assign sweep_done = 1'b1;
`endif

  // The read strobe decodes straight from the state register. The address
  // is forced to zero when idle, so that it never aliases the clear address
  // of the bin returned in the DRAIN cycle.
  assign rd_en  = (state_q == READ) && issue_ok;
  assign rdEn   = rd_en;
  assign rdAddr = rd_en ? addr_q : '0;

  assign rdBank    = bank_q;
  assign clrEn     = clr_en_q;
  assign clrAddr   = clr_addr_q;
  assign busy      = busy_q;
  assign peakValid = peak_valid_q;
  assign peakBin   = peak_bin_q;
  assign peakCount = peak_count_q;

  // Next-state logic. The data-return path is independent of the FSM state:
  // the clear strobe for a bin is the delayed read strobe, and the peak
  // compare runs in that same cycle. A strict compare keeps the lowest bin
  // on ties.
  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    addr_d       = addr_q;
    busy_d       = busy_q;
    peak_valid_d = 1'b0;
    peak_bin_d   = peak_bin_q;
    peak_count_d = peak_count_q;
    clr_en_d     = rd_en;
    clr_addr_d   = rd_en ? addr_q : clr_addr_q;

    if (clr_en_q && (rdData > peak_count_q)) begin
      peak_count_d = rdData;
      peak_bin_d   = clr_addr_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = READ;
          bank_d       = hisNum;
          addr_d       = '0;
          busy_d       = 1'b1;
          peak_bin_d   = '0;
          peak_count_d = '0;
        end
      end
      READ: begin
        // The address holds on a stalled cycle and never wraps.
        if (rd_en) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + NB'(1);
          end
        end
      end
      DRAIN: begin
        if (sweep_done) begin
          state_d      = DONE;
          busy_d       = 1'b0;
          peak_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All sweep state is held here. An asynchronous reset abandons a sweep
  // in progress without producing a peakValid pulse.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= IDLE;
      bank_q       <= 1'b0;
      addr_q       <= '0;
      clr_en_q     <= 1'b0;
      clr_addr_q   <= '0;
      busy_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      addr_q       <= addr_d;
      clr_en_q     <= clr_en_d;
      clr_addr_q   <= clr_addr_d;
      busy_q       <= busy_d;
      peak_valid_q <= peak_valid_d;
      peak_bin_q   <= peak_bin_d;
      peak_count_q <= peak_count_d;
    end
  end

endmodule

// File: tb/tb_his_peak_reader.sv
// Testbench for his_peak_reader.
// Models the two-bank histogram RAM (read data returned one cycle after
// rdEn) and computes the expected peak directly from the bank contents: the
// first bin holding the maximum count.
module tb_his_peak_reader;

  localparam int NB    = 6;
  localparam int CW    = 8;
  localparam int NBINS = 1 << NB;
`ifdef HIS_STREAM_OUT_EN
  localparam int LAT = NBINS + 3;
`else
  localparam int LAT = NBINS + 2;
`endif

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          start = 1'b0;
  logic          hisNum = 1'b0;
  logic          rdEn, rdBank, clrEn, busy, peakValid;
  logic [NB-1:0] rdAddr, clrAddr, peakBin;
  logic [CW-1:0] rdData, peakCount;
`ifdef HIS_STREAM_OUT_EN
  logic          binValid;
  logic          binReady = 1'b1;
  logic [NB-1:0] binAddr;
  logic [CW-1:0] binData;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [CW-1:0] ram [2][NBINS];

  always #5 clk = ~clk;

  his_peak_reader #(.NB(NB), .CW(CW)) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .hisNum    (hisNum),
    .rdEn      (rdEn),
    .rdBank    (rdBank),
    .rdAddr    (rdAddr),
    .rdData    (rdData),
    .clrEn     (clrEn),
    .clrAddr   (clrAddr),
    .busy      (busy),
    .peakValid (peakValid),
    .peakBin   (peakBin),
    .peakCount (peakCount)
`ifdef HIS_STREAM_OUT_EN
    ,
    .binValid  (binValid),
    .binReady  (binReady),
    .binAddr   (binAddr),
    .binData   (binData)
`endif
  );

  // RAM read port with one cycle of latency.
  always @(posedge clk) begin
    if (rdEn) rdData <= ram[rdBank][rdAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fillConst(input bit b, input int val);
    for (int i = 0; i < NBINS; i++) ram[b][i] = CW'(val);
  endtask

  task automatic fillRandom(input bit b, input int maxVal);
    for (int i = 0; i < NBINS; i++) ram[b][i] = CW'($urandom_range(0, maxVal));
  endtask

  // Reference peak: the first index holding the largest count, with zero as the floor.
  task automatic refPeak(input bit b, output int bin, output int cnt);
    bin = 0;
    cnt = 0;
    for (int i = 0; i < NBINS; i++) begin
      if (int'(ram[b][i]) > cnt) begin
        cnt = int'(ram[b][i]);
        bin = i;
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".outs"},
                {1'b0, rdEn, rdBank, rdAddr, clrEn, clrAddr, busy, peakValid, peakBin, peakCount}, 32'd0);
`ifdef HIS_STREAM_OUT_EN
    checkOutput({tag, ".stream"}, {17'd0, binValid, binAddr, binData}, 32'd0);
`endif
  endtask

  // One complete sweep. The task returns on the peakValid cycle, plus
  // `tail` idle cycles. `stray` is the cycle on which a second start is
  // raised with the other bank selected. When `toggle` is set, binReady
  // follows the pattern 1,0,0,1 (stream build).
  task automatic applyStimulus(input bit bank, input int stray, input int tail,
                               input bit toggle, input string name);
    int expBin, expCnt;
    int n = 0, pvCycle = -1, extraPv = 0;
    int rdFirst = -1, clrFirst = -1, rdNext = 0, clrNext = 0;
    int rdErr = 0, clrErr = 0, busyErr = 0, bankErr = 0, collErr = 0;
`ifdef HIS_STREAM_OUT_EN
    int occ = 0, acc = 0, fullErr = 0, strErr = 0;
`endif
    refPeak(bank, expBin, expCnt);
    @(negedge clk);
    start  = 1'b1;
    hisNum = bank;
    while (n < 400 && pvCycle < 0) begin
      @(negedge clk);
      n++;
      start  = (n == stray);
      hisNum = (n == stray) ? ~bank : bank;
`ifdef HIS_STREAM_OUT_EN
      binReady = toggle ? (((n - 1) % 4 == 0) || ((n - 1) % 4 == 3)) : 1'b1;
`endif
      #1;
      if (rdEn) begin
        if (rdFirst < 0) rdFirst = n;
        if (int'(rdAddr) != rdNext) rdErr++;
        rdNext++;
      end
      if (clrEn) begin
        if (clrFirst < 0) clrFirst = n;
        if (int'(clrAddr) != clrNext) clrErr++;
        clrNext++;
      end
      if (rdEn && clrEn && rdAddr == clrAddr) collErr++;
      if (rdBank !== bank) bankErr++;
      if (busy !== !peakValid) busyErr++;
`ifdef HIS_STREAM_OUT_EN
      if (rdEn && occ == 2) fullErr++;
      if (binValid && binReady) begin
        if (acc >= NBINS) strErr++;
        else if (int'(binAddr) != acc || binData !== ram[bank][acc]) strErr++;
        acc++;
      end
      if (peakValid && acc != NBINS) strErr++;
      occ = occ + (clrEn ? 1 : 0) - ((binValid && binReady) ? 1 : 0);
`endif
      if (peakValid) pvCycle = n;
    end
    start = 1'b0;
    if (toggle) checkOutput({name, ".pv_seen"}, (pvCycle > 0) ? 32'd1 : 32'd0, 32'd1);
    else begin
      checkOutput({name, ".pv_cycle"}, pvCycle, LAT);
      checkOutput({name, ".rd_first"}, rdFirst, 1);
      checkOutput({name, ".clr_first"}, clrFirst, 2);
    end
    checkOutput({name, ".rd_count"}, rdNext, NBINS);
    checkOutput({name, ".rd_order"}, rdErr, 0);
    checkOutput({name, ".clr_count"}, clrNext, NBINS);
    checkOutput({name, ".clr_order"}, clrErr, 0);
    checkOutput({name, ".addr_collide"}, collErr, 0);
    checkOutput({name, ".rdBank"}, bankErr, 0);
    checkOutput({name, ".busy"}, busyErr, 0);
    checkOutput({name, ".peakBin"}, peakBin, expBin);
    checkOutput({name, ".peakCount"}, peakCount, expCnt);
`ifdef HIS_STREAM_OUT_EN
    checkOutput({name, ".bins_accepted"}, acc, NBINS);
    checkOutput({name, ".bin_stream"}, strErr, 0);
    checkOutput({name, ".rd_when_full"}, fullErr, 0);
`endif
    if (tail > 0) begin
      repeat (tail) begin
        @(negedge clk);
        if (peakValid || busy) extraPv++;
      end
      checkOutput({name, ".extra_pv"}, extraPv, 0);
      checkOutput({name, ".hold"}, {peakBin, peakCount}, {expBin[NB-1:0], expCnt[CW-1:0]});
    end
  endtask

  initial begin
    int pvc;
    bit b;
    res = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    res = 1'b1;
    @(negedge clk);

    // Single peak at bin 17 over a floor of 3.
    fillConst(0, 3);
    ram[0][17] = 8'd200;
    applyStimulus(1'b0, 0, 5, 1'b0, "single");

    // Saturated tie between the two edge bins, bank 1.
    fillConst(1, 0);
    ram[1][0]  = 8'd255;
    ram[1][63] = 8'd255;
    applyStimulus(1'b1, 0, 0, 1'b0, "tie");

    // All-zero bank, started on the cycle right after the previous peakValid.
    fillConst(0, 0);
    applyStimulus(1'b0, 0, 5, 1'b0, "zero_b2b");

    // A second start at cycle 10 with the other bank selected is ignored.
    fillRandom(1, 255);
    applyStimulus(1'b1, 10, 10, 1'b0, "stray");

    // Reset at cycle 30 of a sweep.
    fillRandom(0, 255);
    @(negedge clk);
    start  = 1'b1;
    hisNum = 1'b1;
    repeat (30) begin
      @(negedge clk);
      start = 1'b0;
    end
    res = 1'b0;
    #1;
    checkAllZero("rst_mid");
    pvc = 0;
    repeat (3) begin
      @(negedge clk);
      if (peakValid) pvc++;
    end
    res = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (peakValid || busy) pvc++;
    end
    checkOutput("rst_mid.no_pv", pvc, 0);
    applyStimulus(1'b0, 0, 3, 1'b0, "after_rst");

    // Random banks: a wide value range, then a narrow one to force ties.
    for (int k = 0; k < 4; k++) begin
      b = 1'($urandom_range(0, 1));
      fillRandom(b, (k < 2) ? 255 : 7);
      applyStimulus(b, 0, 3, 1'b0, "rand");
    end

`ifdef HIS_STREAM_OUT_EN
    fillRandom(1, 255);
    applyStimulus(1'b1, 0, 5, 1'b1, "stream_toggle");
    binReady = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
